// File: rtl/nes_pad_responder_if.sv
// NES pad serial link: the host drives latch/pulse, the responder returns data and frame status.
interface nes_pad_responder_if;
    logic       latch;
    logic       pulse;
    logic       data_out;
    logic [3:0] bit_index;
    logic       frame_done;
    logic       overrun;

    modport master (
        output latch, pulse,
        input  data_out, bit_index, frame_done, overrun
    );

    modport slave (
        input  latch, pulse,
        output data_out, bit_index, frame_done, overrun
    );
endinterface

// File: rtl/nes_pad_responder.sv
// Emulates the NES pad's 4021 shift register on an asynchronous latch/pulse link.
// Define DEBOUNCE_EN to add a per-button debounce filter in front of the load path.
module nes_pad_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        FILL_BIT    = 1'b0
`ifdef DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         buttons,
    nes_pad_responder_if.slave pad
);
    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] pulse_sync_q;
    logic                   pulse_dly_q;
    logic                   latch_s;
    logic                   pulse_s;
    logic                   pulse_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_sync_q <= '0;
            pulse_sync_q <= '0;
            pulse_dly_q  <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pad.latch};
            pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], pad.pulse};
            pulse_dly_q  <= pulse_s;
        end
    end

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
    assign pulse_rise = pulse_s & ~pulse_dly_q;

    logic [7:0] btn_meta_q;
    logic [7:0] btn_sync_q;
    logic [7:0] btn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            btn_meta_q <= buttons;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [7:0]      stable_q;
    logic [CntW-1:0] cnt_q [8];

    // Stable value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (btn_sync_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q[i] <= btn_sync_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign btn = stable_q;
`else
    assign btn = btn_sync_q;
`endif

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] bit_index_q, bit_index_d;
    logic       frame_done_q, frame_done_d;
    logic       overrun_q, overrun_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            shreg_q      <= 8'h00;
            bit_index_q  <= 4'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_index_q  <= bit_index_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_index_d  = bit_index_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        // A high latch overrides everything, including an aborted frame or a coincident pulse.
        if (latch_s) begin
            state_d     = StLoad;
            shreg_d     = btn;
            bit_index_d = 4'd0;
            overrun_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle:  state_d = StIdle;
                StLoad:  state_d = StShift;
                StShift: begin
                    if (pulse_rise) begin
                        shreg_d     = {1'b0, shreg_q[7:1]};
                        bit_index_d = bit_index_q + 4'd1;
                        if (bit_index_q == 4'd7) begin
                            frame_done_d = 1'b1;
                            state_d      = StDone;
                        end
                    end
                end
                StDone: begin
                    if (pulse_rise) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            StLoad, StShift: pad.data_out = ~shreg_q[0];
            StDone:          pad.data_out = FILL_BIT;
            default:         pad.data_out = 1'b1;
        endcase
    end

    assign pad.bit_index  = bit_index_q;
    assign pad.frame_done = frame_done_q;
    assign pad.overrun    = overrun_q;
endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: table of frames, hand corner cases, random frames.
module tb_nes_pad_responder;
    localparam int unsigned SyncStages = 2;
    localparam logic        FillBit    = 1'b0;
`ifdef DEBOUNCE_EN
    localparam int PreWait = 24;
`else
    localparam int PreWait = 4;
`endif

    typedef struct {
        logic [7:0] btn;
        int         npulse;
        int         hi;
        int         lo;
        int         exp_idx;
        logic       exp_ovr;
        int         exp_fd;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] buttons = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         fd_cnt = 0;

    nes_pad_responder_if pad ();

    nes_pad_responder #(
        .SYNC_STAGES(SyncStages),
        .FILL_BIT   (FillBit)
`ifdef DEBOUNCE_EN
        ,
        .DEBOUNCE_CYCLES(16)
`endif
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .buttons(buttons),
        .pad    (pad)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (pad.frame_done === 1'b1) fd_cnt++;
        end
    endtask

    // Host-side frame: latch, then npulse pulses, sampling data_out at each pulse rise.
    task automatic run_frame(input string tag, input logic [7:0] drive, input logic [7:0] model,
                             input int pre, input int latch_cyc, input int np, input int hi,
                             input int lo, input int exp_idx, input logic exp_ovr,
                             input int exp_fd);
        logic e;
        buttons = drive;
        tick(pre);
        fd_cnt = 0;
        pad.latch = 1'b1;
        tick(latch_cyc);
        check({tag, " load idx"}, pad.bit_index, 0);
        check({tag, " load ovr"}, pad.overrun, 0);
        e = ~model[0];
        check({tag, " load data"}, pad.data_out, e);
        pad.latch = 1'b0;
        tick(SyncStages + 3);
        for (int i = 0; i < np; i++) begin
            e = (i < 8) ? ~model[i] : FillBit;
            check($sformatf("%s sample%0d", tag, i + 1), pad.data_out, e);
            pad.pulse = 1'b1;
            tick(hi);
            pad.pulse = 1'b0;
            tick(lo);
        end
        check({tag, " idx"}, pad.bit_index, exp_idx);
        check({tag, " ovr"}, pad.overrun, exp_ovr);
        check({tag, " fdone"}, fd_cnt, exp_fd);
        e = (np < 8) ? ~model[np] : FillBit;
        check({tag, " final data"}, pad.data_out, e);
    endtask

    initial begin
        vec_t       vecs [6];
        logic [7:0] rb;
        int         np, hi, lo, lc;
        logic       e;

        vecs[0] = '{8'b0000_0101, 8, 12, 12, 8, 1'b0, 1};
        vecs[1] = '{8'b0000_0101, 9, 12, 12, 8, 1'b1, 1};
        vecs[2] = '{8'hA5, 3, 12, 12, 3, 1'b0, 0};
        vecs[3] = '{8'h80, 8, 12, 12, 8, 1'b0, 1};
        vecs[4] = '{8'hFF, 0, 12, 12, 0, 1'b0, 0};
        vecs[5] = '{8'h3C, 10, 4, 4, 8, 1'b1, 1};

        pad.latch = 1'b0;
        pad.pulse = 1'b0;
        tick(3);
        check("rst data", pad.data_out, 1);
        check("rst idx", pad.bit_index, 0);
        check("rst fdone", pad.frame_done, 0);
        check("rst ovr", pad.overrun, 0);
        reset = 1'b1;
        tick(3);

        // Pulses in IDLE are ignored.
        pad.pulse = 1'b1;
        tick(6);
        pad.pulse = 1'b0;
        tick(6);
        check("idle pulse idx", pad.bit_index, 0);
        check("idle pulse data", pad.data_out, 1);
        check("idle pulse ovr", pad.overrun, 0);

        for (int v = 0; v < 6; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].btn, vecs[v].btn, PreWait, 12,
                      vecs[v].npulse, vecs[v].hi, vecs[v].lo, vecs[v].exp_idx,
                      vecs[v].exp_ovr, vecs[v].exp_fd);
        end

        // Latch and pulse rising together: latch wins, no shift.
        buttons = 8'h5B;
        tick(PreWait);
        pad.latch = 1'b1;
        pad.pulse = 1'b1;
        tick(8);
        pad.pulse = 1'b0;
        tick(6);
        check("coinc idx", pad.bit_index, 0);
        check("coinc data", pad.data_out, 0);
        pad.latch = 1'b0;
        tick(6);
        check("coinc shift idx", pad.bit_index, 0);
        check("coinc shift data", pad.data_out, 0);

        // Asynchronous reset in the middle of a frame.
        run_frame("pre-rst", 8'hC3, 8'hC3, PreWait, 12, 4, 12, 12, 4, 1'b0, 0);
        #7;
        reset = 1'b0;
        #1;
        check("midrst data", pad.data_out, 1);
        check("midrst idx", pad.bit_index, 0);
        check("midrst ovr", pad.overrun, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        check("midrst held data", pad.data_out, 1);
        run_frame("post-rst", 8'h96, 8'h96, PreWait, 12, 8, 12, 12, 8, 1'b0, 1);

`ifdef DEBOUNCE_EN
        // A chatters, then is held: the frame inside the settle window still sees it released.
        for (int i = 0; i < 20; i++) begin
            buttons = (i % 2 == 1) ? 8'h01 : 8'h00;
            tick(5);
        end
        run_frame("bounce", 8'h01, 8'h00, 0, 4, 8, 6, 6, 8, 1'b0, 1);
        tick(20);
        run_frame("settled", 8'h01, 8'h01, PreWait, 12, 8, 6, 6, 8, 1'b0, 1);
`endif

        for (int r = 0; r < 20; r++) begin
            rb = 8'($urandom);
            np = $urandom_range(0, 10);
            hi = $urandom_range(4, 9);
            lo = $urandom_range(4, 9);
            lc = $urandom_range(4, 12);
            e  = (np > 8);
            run_frame($sformatf("rnd%0d", r), rb, rb, PreWait, lc, np, hi, lo,
                      (np > 8) ? 8 : np, e, (np >= 8) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
